hf_uio_arbiter: RTL and testbench

// - Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of tt_um_hf between NREQ internal requesters.
// - Each requester either drives bytes out or samples bytes in, in bursts.
// - Round-robin arbitration; turnaround cycles with pads tri-stated whenever bus direction changes.
// - Sits between the core datapath and the top-level uio ports; sole owner of uio_oe.

---
 rtl/hf_pkg.sv | 21 ++
 rtl/hf_rr_pick.sv | 36 +++
 rtl/hf_uio_arbiter.sv | 176 +++++++++++++++++
 tb/tb_hf_uio_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hf_pkg.sv
// Purpose : shared types and constants for the uio pad-bus arbiter.
// Latency : n/a (package only).
// Backpressure: n/a. Exports arb_state_e, UIO_W, OE_OUT, OE_IN, oe_for().
package hf_pkg;

  localparam int         UIO_W  = 8;
  localparam logic [7:0] OE_OUT = 8'hFF;
  localparam logic [7:0] OE_IN  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  // Pad enable pattern for a bus direction (1 = drive pads).
  function automatic logic [7:0] oe_for(input logic dir);
    return dir ? OE_OUT : OE_IN;
  endfunction

endpackage

// File: rtl/hf_rr_pick.sv
// Purpose : combinational round-robin picker; first set request at or after ptr_i, wrapping.
// Latency : 0 cycles (pure combinational).
// Backpressure: none. Ports: req_i, ptr_i in; onehot_o, idx_o, any_o out.
module hf_rr_pick
  import hf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int   j;
    logic found;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/hf_uio_arbiter.sv
// Purpose : shares the 8-bit bidirectional uio pad bus between NREQ burst requesters (round robin,
//           tri-stated turnaround on direction change); sole owner of uio_oe. All outputs registered.
// Latency : grant 1 cycle after request seen in IDLE; pad byte / rd_data 1 cycle after each beat.
// Backpressure: requester holds req until its burst ends (req_last, MAXBURST beats, or req drop).
// Ports: clk, rst_n, ena; req/req_dir/req_data/req_last in; gnt, rd_data/rd_valid/rd_id out;
//        uio_in in; uio_out/uio_oe out.
module hf_uio_arbiter
  import hf_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TURN     = 1,
  parameter int MAXBURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_dir,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     gnt,
  output logic [UIO_W-1:0]    rd_data,
  output logic                rd_valid,
  output logic [2:0]          rd_id,
  input  logic [UIO_W-1:0]    uio_in,
  output logic [UIO_W-1:0]    uio_out,
  output logic [UIO_W-1:0]    uio_oe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST + 1);
  localparam int TW = 2;

  // The TURN parameter hides the imported enum literal, so states are
  // always referenced through the package scope.
  hf_pkg::arb_state_e state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             cur_dir_q, cur_dir_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [UIO_W-1:0] uio_oe_q, uio_oe_d;
  logic [UIO_W-1:0] uio_out_q, uio_out_d;
  logic [UIO_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [2:0]       rd_id_q, rd_id_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  hf_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    logic burst_end;
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    cur_dir_d  = cur_dir_q;
    beat_cnt_d = beat_cnt_q;
    turn_cnt_d = turn_cnt_q;
    uio_oe_d   = uio_oe_q;
    uio_out_d  = uio_out_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_valid_d = 1'b0;
    burst_end  = 1'b0;

    if (!ena) begin
      // Abandon any burst; rr_ptr survives so fairness resumes on re-enable.
      state_d    = hf_pkg::IDLE;
      gnt_d      = '0;
      cur_dir_d  = 1'b0;
      beat_cnt_d = '0;
      turn_cnt_d = '0;
      uio_oe_d   = OE_IN;
      uio_out_d  = '0;
    end else begin
      case (state_q)
        hf_pkg::IDLE: begin
          if (pick_any) begin
            gnt_d      = pick_onehot;
            idx_d      = pick_idx;
            beat_cnt_d = '0;
            if (req_dir[pick_idx] == cur_dir_q) begin
              state_d = hf_pkg::XFER;
            end else begin
              state_d    = hf_pkg::TURN;
              turn_cnt_d = '0;
              uio_oe_d   = OE_IN;
              uio_out_d  = '0;
            end
          end
        end
        hf_pkg::TURN: begin
          if (turn_cnt_q == TW'(TURN - 1)) begin
            state_d   = hf_pkg::XFER;
            cur_dir_d = req_dir[idx_q];
            uio_oe_d  = oe_for(req_dir[idx_q]);
          end else begin
            turn_cnt_d = turn_cnt_q + 1'b1;
          end
        end
        hf_pkg::XFER: begin
          if (req[idx_q]) begin
            if (cur_dir_q) begin
              uio_out_d = req_data[8*idx_q +: 8];
            end else begin
              rd_data_d  = uio_in;
              rd_id_d    = 3'(idx_q);
              rd_valid_d = 1'b1;
            end
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (req_last[idx_q] || beat_cnt_q == BW'(MAXBURST - 1)) burst_end = 1'b1;
          end else begin
            // Requester withdrew: release without a beat.
            burst_end = 1'b1;
          end
          if (burst_end) begin
            state_d    = hf_pkg::IDLE;
            gnt_d      = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = hf_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= hf_pkg::IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      cur_dir_q  <= 1'b0;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      uio_oe_q   <= OE_IN;
      uio_out_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_dir_q  <= cur_dir_d;
      beat_cnt_q <= beat_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      uio_oe_q   <= uio_oe_d;
      uio_out_q  <= uio_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign gnt      = gnt_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign uio_out  = uio_out_q;
  assign uio_oe   = uio_oe_q;

endmodule

// File: tb/tb_hf_uio_arbiter.sv
// Purpose : directed self-checking bench for hf_uio_arbiter (NREQ=4, TURN=2, MAXBURST=8).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: bench acts as well-behaved requesters, dropping req once a burst ends.
module tb_hf_uio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  req_dir;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  rd_id;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int n_cmp = 0;
  int n_err = 0;
  int beats;

  hf_uio_arbiter #(.NREQ(4), .TURN(2), .MAXBURST(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req      (req),
    .req_dir  (req_dir),
    .req_data (req_data),
    .req_last (req_last),
    .gnt      (gnt),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .uio_in   (uio_in),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req = '0; req_dir = '0; req_data = '0; req_last = '0; uio_in = '0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_out", uio_out, 8'h00);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_rdd", rd_data, 8'h00);
    chk("rst_rdid", rd_id, 3'd0);
    rst_n = 1'b1;

    // Two out bursts, req0 then req2; first needs a turnaround from the reset input direction.
    req = 4'b0101; req_dir = 4'b0101; req_last = 4'b0101; req_data = 32'h003C_00A5;
    tick(); chk("a_gnt0", gnt, 4'b0001); chk("a_turn_oe1", uio_oe, 8'h00);
    tick(); chk("a_turn_oe2", uio_oe, 8'h00);
    tick(); chk("a_xfer_oe", uio_oe, 8'hFF); chk("a_xfer_gnt", gnt, 4'b0001);
    tick(); chk("a_out_a5", uio_out, 8'hA5); chk("a_idle_gap", gnt, 4'b0000);
    req = 4'b0100;
    tick(); chk("a_gnt2", gnt, 4'b0100); chk("a_no_turn", uio_oe, 8'hFF);
    tick(); chk("a_out_3c", uio_out, 8'h3C); chk("a_rel2", gnt, 4'b0000);

    // Requester 1 out, then requester 2 in: two tri-stated turnaround cycles.
    req = 4'b0110; req_dir = 4'b0010; req_last = 4'b0110; req_data = 32'h0000_1100; uio_in = 8'h5A;
    tick(); chk("b_gnt1", gnt, 4'b0010); chk("b_oe_out", uio_oe, 8'hFF);
    tick(); chk("b_out_11", uio_out, 8'h11); chk("b_rel1", gnt, 4'b0000);
    req = 4'b0100;
    tick(); chk("b_gnt2", gnt, 4'b0100); chk("b_turn_oe1", uio_oe, 8'h00); chk("b_turn_out", uio_out, 8'h00);
    tick(); chk("b_turn_oe2", uio_oe, 8'h00); chk("b_no_rd_t2", rd_valid, 1'b0);
    tick(); chk("b_xfer_oe", uio_oe, 8'h00); chk("b_no_rd_x", rd_valid, 1'b0);
    tick(); chk("b_rdv", rd_valid, 1'b1); chk("b_rdd", rd_data, 8'h5A); chk("b_rdid", rd_id, 3'd2);
    chk("b_rel2", gnt, 4'b0000);
    req = 4'b0000;
    tick(); chk("b_strobe_once", rd_valid, 1'b0);

    // Requester 3 never sends last: forced release after MAXBURST beats; rr wraps to 0.
    req = 4'b1111; req_dir = 4'b0000; req_last = 4'b0000; uio_in = 8'hC3;
    tick(); chk("c_gnt3", gnt, 4'b1000);
    beats = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (rd_valid && rd_id == 3'd3) beats++;
      if (k == 1) chk("c_rdd", rd_data, 8'hC3);
      if (k == 8) begin
        chk("c_release", gnt, 4'b0000);
        req = 4'b0111;
      end
    end
    chk("c_next_gnt", gnt, 4'b0001);
    chk("c_beats", beats, 8);

    // Requester 0 withdraws after 3 beats; rr_ptr moves to 1.
    beats = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (rd_valid && rd_id == 3'd0) beats++;
      if (k == 3) req = 4'b0110;
    end
    chk("d_beats", beats, 3);
    chk("d_rel0", gnt, 4'b0000);
    chk("d_no_beat", rd_valid, 1'b0);
    tick(); chk("d_rr_ptr", gnt, 4'b0010);
    req = 4'b0000;
    tick(); chk("d_rel1", gnt, 4'b0000); chk("d_drop_nobeat", rd_valid, 1'b0);

    // ena dropped mid out-burst, then re-enabled: arbitration resumes from saved rr_ptr.
    req = 4'b1100; req_dir = 4'b1100; req_last = 4'b0000; req_data = 32'h8877_0000;
    tick(); chk("e_gnt2", gnt, 4'b0100);
    tick();
    tick(); chk("e_oe_out", uio_oe, 8'hFF);
    tick(); chk("e_out_77", uio_out, 8'h77);
    ena = 1'b0;
    tick(); chk("e_ena_gnt", gnt, 4'b0000); chk("e_ena_oe", uio_oe, 8'h00); chk("e_ena_out", uio_out, 8'h00);
    ena = 1'b1;
    tick(); chk("e_resume_ptr", gnt, 4'b0100); chk("e_resume_oe", uio_oe, 8'h00);

    // Asynchronous reset while driving pads.
    tick();
    tick(); chk("f_oe_out", uio_oe, 8'hFF);
    tick(); chk("f_out_77", uio_out, 8'h77); chk("f_gnt2", gnt, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_oe", uio_oe, 8'h00);
    chk("f_async_gnt", gnt, 4'b0000);
    chk("f_async_out", uio_out, 8'h00);
    req = 4'b1111; req_dir = 4'b0000; req_last = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick(); chk("f_first_gnt", gnt, 4'b0001);
    tick(); chk("f_rdv", rd_valid, 1'b1); chk("f_rdid", rd_id, 3'd0);
    req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
